// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI Wishbone sequencer: FSM states, simple_spi
// register map and register bit positions.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        INIT_CR, INIT_ER, IDLE, WR_DR, RD_SR, RD_DR, RX_HOLD, ERR
    } state_e;

    localparam logic [1:0] ADR_SPCR = 2'd0;
    localparam logic [1:0] ADR_SPSR = 2'd1;
    localparam logic [1:0] ADR_SPDR = 2'd2;
    localparam logic [1:0] ADR_SPER = 2'd3;

    localparam int SPCR_SPIE    = 7;
    localparam int SPCR_SPE     = 6;
    localparam int SPCR_MSTR    = 4;
    localparam int SPCR_CPOL    = 3;
    localparam int SPCR_CPHA    = 2;
    localparam int SPSR_RFEMPTY = 0;

    // Core enabled, master mode, interrupts off.
    function automatic logic [7:0] spcr_value(input logic cpol, input logic cpha,
                                              input logic [1:0] spr);
        logic [7:0] v;
        v = {6'b0, spr};
        v[SPCR_SPIE] = 1'b0;
        v[SPCR_SPE]  = 1'b1;
        v[SPCR_MSTR] = 1'b1;
        v[SPCR_CPOL] = cpol;
        v[SPCR_CPHA] = cpha;
        return v;
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// Issues one Wishbone classic access per start request and aborts it when
// no ack arrives within ACK_TIMEOUT strobe cycles.
module wb_single_master #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start,
    input  logic       we,
    input  logic [1:0] adr,
    input  logic [7:0] wdat,
    output logic       done,
    output logic       timeout,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic       wb_ack_i
);

    logic       cyc_q;
    logic       we_q;
    logic [1:0] adr_q;
    logic [7:0] dat_q;
    logic [7:0] cnt;

    // An ack on the terminal-count cycle wins over the timeout.
    assign done    = cyc_q && wb_ack_i;
    assign timeout = cyc_q && !wb_ack_i && (cnt == 8'(ACK_TIMEOUT - 1));

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = {6'b0, adr_q};
    assign wb_dat_o = dat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= 2'b0;
            dat_q <= 8'h00;
            cnt   <= 8'h00;
        end else if (cyc_q) begin
            if (done || timeout) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
                adr_q <= 2'b0;
                dat_q <= 8'h00;
                cnt   <= 8'h00;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end else if (start) begin
            cyc_q <= 1'b1;
            we_q  <= we;
            adr_q <= adr;
            dat_q <= we ? wdat : 8'h00;
            cnt   <= 8'h00;
        end
    end

endmodule

// File: rtl/spi_wb_sequencer.sv
// Drives simple_spi_top over Wishbone: configures SPCR/SPER, then for each
// tx byte writes SPDR, polls SPSR until the rx FIFO is non-empty, reads SPDR.
module spi_wb_sequencer
    import spi_seq_pkg::*;
#(
    parameter logic [1:0] SPR         = 2'b00,
    parameter logic [1:0] ESPR        = 2'b00,
    parameter logic       CPOL        = 1'b0,
    parameter logic       CPHA        = 1'b0,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy_o,
    output logic       err_o,
    input  logic       err_clr_i
);

    state_e     state, state_n;
    logic       acc_start, acc_we, acc_done, acc_timeout;
    logic [1:0] acc_adr;
    logic [7:0] acc_wdat;
    logic [7:0] tx_byte;
    logic [7:0] rx_q;
    logic       err_q;

    wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_master (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start    (acc_start),
        .we       (acc_we),
        .adr      (acc_adr),
        .wdat     (acc_wdat),
        .done     (acc_done),
        .timeout  (acc_timeout),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_ack_i (wb_ack_i)
    );

    assign tx_ready = (state == IDLE);
    assign rx_valid = (state == RX_HOLD);
    assign busy_o   = (state != IDLE);
    assign rx_data  = rx_q;
    assign err_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= INIT_CR;
            tx_byte <= 8'h00;
            rx_q    <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && tx_valid)
                tx_byte <= tx_data;
            if (state == RD_DR && acc_done)
                rx_q <= wb_dat_i;
            if (acc_timeout)
                err_q <= 1'b1;
            else if (state == ERR && err_clr_i)
                err_q <= 1'b0;
        end
    end

    always_comb begin
        state_n   = state;
        acc_start = 1'b0;
        acc_we    = 1'b0;
        acc_adr   = 2'b0;
        acc_wdat  = 8'h00;
        // Every access state requests a transfer whenever the master is idle;
        // the state moves on the same edge the master retires the access.
        unique case (state)
            INIT_CR: begin
                acc_start = !wb_cyc_o;
                acc_we    = 1'b1;
                acc_adr   = ADR_SPCR;
                acc_wdat  = spcr_value(CPOL, CPHA, SPR);
                if (acc_done) state_n = INIT_ER;
            end
            INIT_ER: begin
                acc_start = !wb_cyc_o;
                acc_we    = 1'b1;
                acc_adr   = ADR_SPER;
                acc_wdat  = {6'b0, ESPR};
                if (acc_done) state_n = IDLE;
            end
            IDLE: begin
                if (tx_valid) state_n = WR_DR;
            end
            WR_DR: begin
                acc_start = !wb_cyc_o;
                acc_we    = 1'b1;
                acc_adr   = ADR_SPDR;
                acc_wdat  = tx_byte;
                if (acc_done) state_n = RD_SR;
            end
            RD_SR: begin
                acc_start = !wb_cyc_o;
                acc_adr   = ADR_SPSR;
                if (acc_done && !wb_dat_i[SPSR_RFEMPTY]) state_n = RD_DR;
            end
            RD_DR: begin
                acc_start = !wb_cyc_o;
                acc_adr   = ADR_SPDR;
                if (acc_done) state_n = RX_HOLD;
            end
            RX_HOLD: begin
                if (rx_ready) state_n = IDLE;
            end
            ERR: begin
                if (err_clr_i) state_n = INIT_CR;
            end
            default: state_n = INIT_CR;
        endcase
        if (acc_timeout) state_n = ERR;
    end

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Directed bench for spi_wb_sequencer with a task-driven Wishbone slave.
module tb_spi_wb_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0] wb_adr_o, wb_dat_o;
    logic [7:0] wb_dat_i = 8'h00;
    logic       wb_ack_i = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       busy_o, err_o;
    logic       err_clr_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    spi_wb_sequencer #(
        .SPR(2'b01), .ESPR(2'b10), .CPOL(1'b1), .CPHA(1'b0), .ACK_TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    // Waits for a strobe, captures the request, acks after 'delay' cycles.
    // Returns with the bench at the falling edge after the ack edge.
    task automatic serve(input logic [7:0] rdata, input int delay,
                         output logic got, output logic [16:0] req);
        got = 1'b0;
        req = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (wb_stb_o) begin got = 1'b1; break; end
        end
        if (got) begin
            req = {wb_we_o, wb_adr_o, wb_dat_o};
            repeat (delay) @(negedge clk_i);
            if ({wb_we_o, wb_adr_o, wb_dat_o} !== req) req = 17'h1ffff;
            wb_ack_i = 1'b1;
            wb_dat_i = rdata;
            @(negedge clk_i);
            wb_ack_i = 1'b0;
            wb_dat_i = 8'h00;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk_i);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_tests++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_wb: got %b want 0", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o});
        end
        n_tests++;
        if ({tx_ready, rx_valid, rx_data, err_o, busy_o} !== 12'b0_0_00000000_0_1) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000000001", {tx_ready, rx_valid, rx_data, err_o, busy_o});
        end
    endtask

    task automatic check_init(input string tag);
        logic got;
        logic [16:0] req;
        serve(8'h00, 1, got, req);
        n_tests++;
        if (!got || req !== {1'b1, 8'h00, 8'h59}) begin
            n_fail++;
            $display("FAIL %s_spcr: got %h want %h", tag, req, {1'b1, 8'h00, 8'h59});
        end
        n_tests++;
        if (wb_cyc_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_gap: cyc=%b busy=%b want cyc=0 busy=1", tag, wb_cyc_o, busy_o);
        end
        serve(8'h00, 0, got, req);
        n_tests++;
        if (!got || req !== {1'b1, 8'h03, 8'h02}) begin
            n_fail++;
            $display("FAIL %s_sper: got %h want %h", tag, req, {1'b1, 8'h03, 8'h02});
        end
        n_tests++;
        if (busy_o !== 1'b0 || tx_ready !== 1'b1 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b tx_ready=%b err=%b want 0 1 0", tag, busy_o, tx_ready, err_o);
        end
    endtask

    task automatic test_init;
        @(negedge clk_i);
        rst_i = 1'b1;
        check_init("init");
        // Stray ack while no strobe must have no effect.
        wb_ack_i = 1'b1;
        wb_dat_i = 8'hff;
        @(negedge clk_i);
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || err_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: busy=%b err=%b cyc=%b want 0 0 0", busy_o, err_o, wb_cyc_o);
        end
    endtask

    task automatic test_transfer;
        logic got;
        logic [16:0] req;
        logic [7:0] sr [3] = '{8'h05, 8'h05, 8'h04};
        send_byte(8'hA5);
        n_tests++;
        if (busy_o !== 1'b1 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL xfer_accept: busy=%b tx_ready=%b want 1 0", busy_o, tx_ready);
        end
        serve(8'h00, 2, got, req);
        n_tests++;
        if (!got || req !== {1'b1, 8'h02, 8'hA5}) begin
            n_fail++;
            $display("FAIL xfer_spdr_wr: got %h want %h", req, {1'b1, 8'h02, 8'hA5});
        end
        for (int i = 0; i < 3; i++) begin
            serve(sr[i], 1, got, req);
            n_tests++;
            if (!got || req !== {1'b0, 8'h01, 8'h00}) begin
                n_fail++;
                $display("FAIL xfer_spsr_rd%0d: got %h want %h", i, req, {1'b0, 8'h01, 8'h00});
            end
        end
        serve(8'h3C, 0, got, req);
        n_tests++;
        if (!got || req !== {1'b0, 8'h02, 8'h00}) begin
            n_fail++;
            $display("FAIL xfer_spdr_rd: got %h want %h", req, {1'b0, 8'h02, 8'h00});
        end
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL xfer_rx: rx_valid=%b rx_data=%h want 1 3c", rx_valid, rx_data);
        end
    endtask

    task automatic test_rx_stall;
        int bad = 0;
        // An offered byte during the stall must be ignored.
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (rx_valid !== 1'b1 || rx_data !== 8'h3C || tx_ready !== 1'b0 || wb_cyc_o !== 1'b0)
                bad++;
        end
        tx_valid = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rx_stall: %0d bad cycles, want 0", bad);
        end
        rx_ready = 1'b1;
        @(negedge clk_i);
        rx_ready = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b0 || tx_ready !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_release: rx_valid=%b tx_ready=%b busy=%b want 0 1 0", rx_valid, tx_ready, busy_o);
        end
    endtask

    task automatic test_timeout;
        logic found = 1'b0;
        int stb_cycles = 0;
        send_byte(8'h11);
        for (int i = 0; i < 100; i++) begin
            if (wb_stb_o) begin found = 1'b1; break; end
            @(negedge clk_i);
        end
        for (int i = 0; i < 50 && found; i++) begin
            if (!wb_stb_o) break;
            stb_cycles++;
            @(negedge clk_i);
        end
        n_tests++;
        if (!found || stb_cycles != 8) begin
            n_fail++;
            $display("FAIL timeout_len: stb cycles %0d want 8", stb_cycles);
        end
        repeat (2) @(negedge clk_i);
        n_tests++;
        if (err_o !== 1'b1 || wb_cyc_o !== 1'b0 || tx_ready !== 1'b0 || rx_valid !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err: err=%b cyc=%b tx_ready=%b rx_valid=%b busy=%b want 1 0 0 0 1",
                     err_o, wb_cyc_o, tx_ready, rx_valid, busy_o);
        end
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clr: err=%b want 0", err_o);
        end
        check_init("reinit");
    endtask

    task automatic test_ack_at_terminal;
        logic got;
        logic [16:0] req;
        send_byte(8'hC3);
        serve(8'h00, 7, got, req);
        n_tests++;
        if (!got || req !== {1'b1, 8'h02, 8'hC3} || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL terminal_ack: req=%h err=%b want %h 0", req, err_o, {1'b1, 8'h02, 8'hC3});
        end
        serve(8'h00, 0, got, req);
        serve(8'h99, 0, got, req);
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h99 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL terminal_rx: rx_valid=%b rx_data=%h err=%b want 1 99 0", rx_valid, rx_data, err_o);
        end
        rx_ready = 1'b1;
        @(negedge clk_i);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_poll;
        logic got;
        logic [16:0] req;
        logic found = 1'b0;
        send_byte(8'h22);
        serve(8'h00, 0, got, req);
        for (int i = 0; i < 100; i++) begin
            if (wb_stb_o) begin found = 1'b1; break; end
            @(negedge clk_i);
        end
        n_tests++;
        if (!found || wb_adr_o !== 8'h01) begin
            n_fail++;
            $display("FAIL midrst_poll: found=%b adr=%h want 1 01", found, wb_adr_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b1 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_drop: cyc=%b stb=%b busy=%b rx_valid=%b want 0 0 1 0",
                     wb_cyc_o, wb_stb_o, busy_o, rx_valid);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        check_init("midrst");
        n_tests++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_norx: rx_valid=%b rx_data=%h want 0 00", rx_valid, rx_data);
        end
    endtask

    initial begin
        test_reset;
        test_init;
        test_transfer;
        test_rx_stall;
        test_timeout;
        test_ack_at_terminal;
        test_reset_mid_poll;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
